// File: rtl/mesh_link_pkg.sv
// Shared mesh types: word width and word typedef used by every tile-facing link.
package mesh_link_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/mesh_link_if.sv
// Tile-to-tile link bundle: sender handshake in, receiver handshake out, occupancy.
// xfer_cnt/stall_cnt exist only when MESH_LINK_STATS_EN is defined.
interface mesh_link_if
  import mesh_link_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  word_t            snd_data;
  logic             snd_ready;
  logic             snd_done;
  word_t            rcv_data;
  logic             rcv_valid;
  logic             rcv_ready;
  logic [CNT_W-1:0] count;
`ifdef MESH_LINK_STATS_EN
  logic [31:0]      xfer_cnt;
  logic [31:0]      stall_cnt;
`endif

  // master: the tiles on either side; slave: the link itself.
  modport master (
    output snd_data, snd_ready, rcv_ready,
    input  snd_done, rcv_data, rcv_valid, count
`ifdef MESH_LINK_STATS_EN
    , input xfer_cnt, stall_cnt
`endif
  );

  modport slave (
    input  snd_data, snd_ready, rcv_ready,
    output snd_done, rcv_data, rcv_valid, count
`ifdef MESH_LINK_STATS_EN
    , output xfer_cnt, stall_cnt
`endif
  );
endinterface

// File: rtl/mesh_link_fifo.sv
// Power-of-two FIFO with occupancy count; caller guarantees no push when full
// and no pop when empty.
module mesh_link_fifo
  import mesh_link_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  word_t            wdata_i,
  output word_t            rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);

  word_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: storage is deliberately not reset; the pointers and count alone
  // define which entries are live, so clearing the array would only add logic.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  // Forced to zero while empty so the output is clean out of reset.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/mesh_link.sv
// One-direction buffered channel between adjacent mesh tiles.
// Define MESH_LINK_STATS_EN to add saturating transfer/stall counters.
module mesh_link
  import mesh_link_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic       clk,
  input logic       rst,
  mesh_link_if.slave link
);
  logic done_q, done_d;
  logic push, pop, full, empty;

  // The sender retires its word only after seeing snd_done, so acceptance is
  // blocked during the done cycle to avoid taking the same word twice.
  assign push   = link.snd_ready && !full && !done_q;
  assign pop    = !empty && link.rcv_ready;
  assign done_d = push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= done_d;
  end

  mesh_link_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (link.snd_data),
    .rdata_o (link.rcv_data),
    .full_o  (full),
    .empty_o (empty),
    .count_o (link.count)
  );

  assign link.snd_done  = done_q;
  assign link.rcv_valid = !empty;

`ifdef MESH_LINK_STATS_EN
  logic [31:0] xfer_cnt_q, xfer_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    xfer_cnt_d  = xfer_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pop && !(&xfer_cnt_q))                     xfer_cnt_d  = xfer_cnt_q + 1'b1;
    if (link.snd_ready && full && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      xfer_cnt_q  <= xfer_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign link.xfer_cnt  = xfer_cnt_q;
  assign link.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_mesh_link.sv
// Scoreboard bench for mesh_link: a cycle model tracks accepted words, done
// pulses and occupancy; DUT outputs are compared 1 time unit after each edge.
module tb_mesh_link;
  import mesh_link_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mesh_link_if #(.DEPTH(DEPTH)) bus ();

  mesh_link #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (bus.slave)
  );

  word_t sb[$];    // words expected out of the link, in order
  word_t tx_q[$];  // words the sender still has to hand over
  int    m_count;
  bit    m_done;
  int    n_vec;
  int    n_err;
`ifdef MESH_LINK_STATS_EN
  logic [31:0] m_xfer;
  logic [31:0] m_stall;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_count = 0;
    m_done  = 1'b0;
`ifdef MESH_LINK_STATS_EN
    m_xfer  = '0;
    m_stall = '0;
`endif
  endtask

  task automatic drive_sender();
    bus.snd_ready = (tx_q.size() != 0);
    bus.snd_data  = (tx_q.size() != 0) ? tx_q[0] : '0;
  endtask

  task automatic compare();
    check("snd_done", 32'(bus.snd_done), 32'(m_done));
    check("count", 32'(bus.count), m_count);
    check("rcv_valid", 32'(bus.rcv_valid), 32'(m_count != 0));
    if (m_count != 0) check("rcv_data", bus.rcv_data, sb[0]);
`ifdef MESH_LINK_STATS_EN
    check("xfer_cnt", bus.xfer_cnt, m_xfer);
    check("stall_cnt", bus.stall_cnt, m_stall);
`endif
  endtask

  // One clock: predict from pre-edge inputs and model state, then compare.
  task automatic step();
    bit do_push, do_pop, retire, m_full;
    m_full  = (m_count == DEPTH);
    retire  = m_done;
    do_push = bus.snd_ready && !m_full && !m_done;
    do_pop  = (m_count != 0) && bus.rcv_ready;
    @(posedge clk);
    if (do_pop) void'(sb.pop_front());
    if (do_push) sb.push_back(bus.snd_data);
    m_count = sb.size();
    m_done  = do_push;
`ifdef MESH_LINK_STATS_EN
    if (do_pop) m_xfer++;
    if (bus.snd_ready && m_full) m_stall++;
`endif
    if (retire && tx_q.size() != 0) void'(tx_q.pop_front());
    #1;
    drive_sender();
    compare();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.snd_data  = '0;
    bus.snd_ready = 1'b0;
    bus.rcv_ready = 1'b0;
    model_reset();

    // Reset, then idle.
    repeat (2) @(posedge clk);
    #1;
    compare();
    rst = 1'b0;
    repeat (10) step();

    // Single word: done in cycle 1 only, drained by a pop in cycle 3.
    tx_q.push_back(32'hDEAD_BEEF);
    drive_sender();
    repeat (3) step();
    bus.rcv_ready = 1'b1;
    step();
    bus.rcv_ready = 1'b0;
    check("single_drained", 32'(bus.count), 32'd0);

    // Fill to DEPTH with receiver stalled; word 5 is held.
    for (int w = 1; w <= 5; w++) tx_q.push_back(word_t'(w));
    drive_sender();
    repeat (12) step();
    check("fill_count", 32'(bus.count), DEPTH);
    check("fill_held_done", 32'(bus.snd_done), 32'd0);

    // Full with pop and offer together: pop taken, push refused.
    bus.rcv_ready = 1'b1;
    step();
    bus.rcv_ready = 1'b0;
    check("fullpop_count", 32'(bus.count), DEPTH - 1);
    check("fullpop_no_done", 32'(bus.snd_done), 32'd0);
    step();
    check("fullpop_next_push", 32'(bus.count), DEPTH);

    // Drain everything in order.
    bus.rcv_ready = 1'b1;
    repeat (6) step();
    bus.rcv_ready = 1'b0;
    check("fill_drained", 32'(bus.count), 32'd0);

    // Simultaneous push and pop at count 2.
    tx_q.push_back(32'h0000_0010);
    tx_q.push_back(32'h0000_0011);
    tx_q.push_back(32'h0000_0012);
    drive_sender();
    for (int i = 0; i < 20 && !(m_count == 2 && !m_done); i++) step();
    check("pp_setup", 32'(bus.count), 32'd2);
    bus.rcv_ready = 1'b1;
    step();
    check("pp_count", 32'(bus.count), 32'd2);
    repeat (8) step();
    bus.rcv_ready = 1'b0;
    check("pp_drained", 32'(bus.count), 32'd0);

    // Reset mid-stream with a done pulse pending at count 3.
    for (int w = 32'h20; w <= 32'h23; w++) tx_q.push_back(word_t'(w));
    drive_sender();
    for (int i = 0; i < 20 && !(m_count == 3 && m_done); i++) step();
    check("rst_setup", 32'(bus.count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_valid", 32'(bus.rcv_valid), 32'd0);
    check("rst_done", 32'(bus.snd_done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_sender();
    repeat (6) step();
    check("rst_reoffer_count", 32'(bus.count), 32'd2);
    bus.rcv_ready = 1'b1;
    repeat (4) step();
    check("rst_drained", 32'(bus.count), 32'd0);
    check("rst_sender_idle", 32'(bus.snd_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mesh_link.md
Name: mesh_link

Overview:
- One-direction channel between two adjacent tiles in the mesh.
- Consumes one tile's send-side handshake (send_data / send_ready / send_done) and drives the neighbour's receive-side handshake (recv_data / recv_valid / recv_ready).
- Buffers words in a small FIFO, so a sender is not stalled while the receiver is busy.
- The mesh generator places two instances per tile pair, one for each direction.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- snd_data  in  WORD_W  the sender tile's send_data.
- snd_ready  in  1  the sender tile's send_ready (a word is offered).
- snd_done  out  1  one-cycle pulse; the offered word was taken. Goes to the sender tile's send_done.
- rcv_data  out  WORD_W  head of the FIFO; goes to the receiver tile's recv_data.
- rcv_valid  out  1  FIFO is non-empty; goes to the receiver tile's recv_valid.
- rcv_ready  in  1  the receiver tile's recv_ready.
- count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset values: snd_done=0, rcv_valid=0, count=0, rcv_data=0.
  - Read and write pointers clear to 0.
  - Any in-flight word is discarded; storage contents are not cleared.
- Push condition: snd_ready && !full && !snd_done.
  - The !snd_done term is required. The sender sees snd_done in cycle N+1 and only then retires the word. Blocking acceptance in that cycle prevents the same word being pushed twice.
  - Maximum ingress rate is therefore one word per two cycles.
- On a push in cycle N:
  - The word is written at wr_ptr and wr_ptr increments (mod DEPTH).
  - snd_done=1 in cycle N+1 only, for exactly one cycle.
- Pop condition: rcv_valid && rcv_ready.
  - rd_ptr increments at the edge.
  - rcv_data is combinational from mem[rd_ptr], so it is valid in the same cycle rcv_valid is high.
- Latency: a word pushed at edge N is visible on rcv_valid/rcv_data after edge N, i.e. one cycle. There is no bypass.
- full = (count==DEPTH); empty = (count==0); rcv_valid = !empty.
- count update: push only → +1; pop only → -1; both → unchanged.
- Boundary conditions:
  - Full, with pop and snd_ready in the same cycle: the pop is taken and the push is refused, because full is evaluated before the edge. The push is accepted in the next cycle.
  - Empty with snd_ready: the push is accepted; no pop is possible that cycle (rcv_valid=0).
  - Pointers wrap naturally at DEPTH; count distinguishes full from empty.
  - rcv_data is don't-care while rcv_valid=0. The bench must not check it.
  - rst asserted mid-transfer: a pending snd_done pulse is cancelled. The sender keeps snd_ready high and re-offers the word after reset.
- No state machine beyond the done-pulse register. The FIFO is the only storage.

Optional Feature:
- Macro: MESH_LINK_STATS_EN.
- When defined, two extra outputs are added:
  - xfer_cnt (32 bits): increments on every pop.
  - stall_cnt (32 bits): increments every cycle in which snd_ready && full.
  - Both counters saturate at all-ones and reset to 0.
- When not defined, the ports and counters are absent. Core behaviour is identical either way.

Decomposition:
- Shared package (types): WORD_W=32 and the word typedef. These already exist there; the link reuses them and adds nothing.
- Sub-module: mesh_link_fifo (parameterised storage, pointers and count, with push/pop/full/empty).
- mesh_link itself holds the handshake logic (done pulse, push gating) and the optional stats counters.

Test Plan:
- Reset then idle: after rst deasserts, rcv_valid=0, snd_done=0, count=0 for 10 cycles with no stimulus.
- Single word: snd_data=0xDEADBEEF, snd_ready=1 at cycle 0.
  - snd_done=1 in cycle 1 only.
  - rcv_valid=1 and rcv_data=0xDEADBEEF from cycle 1.
  - rcv_ready=1 at cycle 3 → count 1→0 and rcv_valid=0 in cycle 4.
- Fill with DEPTH=4 and rcv_ready=0: sender streams 1,2,3,4,5.
  - Four snd_done pulses, two cycles apart.
  - count=4; word 5 is held with snd_done=0.
  - rcv_ready=1 then drains 1,2,3,4,5 in order.
- Simultaneous push/pop at count=2: count stays 2 and FIFO order is preserved.
- Full with simultaneous pop and offer: the pop occurs, count=3, and no snd_done in the next cycle.
  - Push accepted the following cycle, count=4.
  - With MESH_LINK_STATS_EN, stall_cnt increments for the full cycle.
- Reset mid-stream: rst asserted while count=3 and snd_done is pending.
  - count=0, rcv_valid=0 and snd_done=0 immediately, without waiting for a clock edge.
  - After release, the re-offered word is accepted once.
